// File: rtl/render_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : render_ctrl_pkg
//  Description : Shared screen geometry, FSM state encoding, colour width and
//                the capture-time clamp helper for the render controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package render_ctrl_pkg;

    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int VBLANK_LINE = 480;
    localparam int RGB_W       = 12;
    localparam int COORD_W     = 10;
    // One extra bit so coordinate + size sums never wrap.
    localparam int CMP_W       = COORD_W + 1;

    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_VBLANK = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    typedef logic [RGB_W-1:0] rgb_t;

    // Limit a requested coordinate to the last position where the ball still fits.
    function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] v,
                                                      input logic [CMP_W-1:0]   lim);
        if ({1'b0, v} > lim)
            return lim[COORD_W-1:0];
        else
            return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rect_hit.sv
`default_nettype none
// ============================================================================
//  Module      : rect_hit
//  Description : Combinational inclusive-rectangle test for one pixel.
//  Revision    : 1.0 - initial release
// ============================================================================
module rect_hit
    import render_ctrl_pkg::*;
(
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    input  logic [CMP_W-1:0]   x0,
    input  logic [CMP_W-1:0]   x1,
    input  logic [CMP_W-1:0]   y0,
    input  logic [CMP_W-1:0]   y1,
    output logic               hit
);

    assign hit = ({1'b0, px} >= x0) && ({1'b0, px} <= x1) &&
                 ({1'b0, py} >= y0) && ({1'b0, py} <= y1);

endmodule
`default_nettype wire

// File: rtl/render_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : render_ctrl
//  Description : Ball/hoop pixel renderer with a shadowed ball position that
//                is only committed during vertical blanking (tear-free).
//  Revision    : 1.0 - initial release
// ============================================================================
module render_ctrl
    import render_ctrl_pkg::*;
#(
    parameter int         BALL_SIZE = 16,
    parameter int         HOOP_X0   = 560,
    parameter int         HOOP_X1   = 600,
    parameter int         HOOP_Y0   = 200,
    parameter int         HOOP_Y1   = 208,
    parameter logic [RGB_W-1:0] BG_RGB = 12'h000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               p_tick,
    input  logic               video_on,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               upd_req,
    input  logic [COORD_W-1:0] upd_x,
    input  logic [COORD_W-1:0] upd_y,
    input  logic [RGB_W-1:0]   ball_rgb,
    input  logic [RGB_W-1:0]   hoop_rgb,
    output logic               upd_ack,
    output logic               frame_start,
    output logic               pending,
    output logic [RGB_W-1:0]   rgb
);

    localparam logic [CMP_W-1:0] X_LIM = CMP_W'(SCREEN_W - BALL_SIZE);
    localparam logic [CMP_W-1:0] Y_LIM = CMP_W'(SCREEN_H - BALL_SIZE);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [COORD_W-1:0] live_x;
    logic [COORD_W-1:0] live_y;
    logic [COORD_W-1:0] shadow_x;
    logic [COORD_W-1:0] shadow_y;
    logic               capture;
    logic               at_origin;
    logic               at_vblank_line;
    logic               ball_on;
    logic               hoop_on;
    rgb_t               pix_rgb;

    assign at_origin      = (x == '0) && (y == '0);
    assign at_vblank_line = (x == '0) && (y == COORD_W'(VBLANK_LINE));
    assign frame_start    = p_tick && at_origin;

    // The ack cycle blocks capture so a held request is not taken twice.
    assign capture = upd_req && !pending && !upd_ack;

    // Next-state: commit has priority over starting a frame in blanking.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACTIVE: if (p_tick && at_vblank_line) state_nxt = ST_VBLANK;
            ST_VBLANK: begin
                if (pending)                  state_nxt = ST_COMMIT;
                else if (p_tick && at_origin) state_nxt = ST_ACTIVE;
            end
            ST_COMMIT: state_nxt = ST_VBLANK;
            default:   state_nxt = ST_VBLANK;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_VBLANK;
        else       state <= state_nxt;
    end

    // Request capture into the shadow, and shadow-to-live commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live_x   <= '0;
            live_y   <= '0;
            shadow_x <= '0;
            shadow_y <= '0;
            pending  <= 1'b0;
            upd_ack  <= 1'b0;
        end else begin
            upd_ack <= (state == ST_COMMIT);
            if (state == ST_COMMIT) begin
                live_x  <= shadow_x;
                live_y  <= shadow_y;
                pending <= 1'b0;
            end else if (capture) begin
                shadow_x <= clamp_coord(upd_x, X_LIM);
                shadow_y <= clamp_coord(upd_y, Y_LIM);
                pending  <= 1'b1;
            end
        end
    end

    rect_hit u_ball_hit (
        .px (x),
        .py (y),
        .x0 ({1'b0, live_x}),
        .x1 ({1'b0, live_x} + CMP_W'(BALL_SIZE - 1)),
        .y0 ({1'b0, live_y}),
        .y1 ({1'b0, live_y} + CMP_W'(BALL_SIZE - 1)),
        .hit(ball_on)
    );

    rect_hit u_hoop_hit (
        .px (x),
        .py (y),
        .x0 (CMP_W'(HOOP_X0)),
        .x1 (CMP_W'(HOOP_X1)),
        .y0 (CMP_W'(HOOP_Y0)),
        .y1 (CMP_W'(HOOP_Y1)),
        .hit(hoop_on)
    );

    // Layer priority: blanking, then ball, then hoop, then background.
    always_comb begin
        pix_rgb = BG_RGB;
        if (!video_on)    pix_rgb = '0;
        else if (ball_on) pix_rgb = ball_rgb;
        else if (hoop_on) pix_rgb = hoop_rgb;
    end

    // Output colour register, advanced once per pixel tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       rgb <= '0;
        else if (p_tick) rgb <= pix_rgb;
    end

endmodule
`default_nettype wire

// File: tb/tb_render_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_render_ctrl
//  Description : Directed, table-driven self-checking bench for render_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_render_ctrl;

    localparam logic [11:0] B = 12'hABC;   // ball colour
    localparam logic [11:0] H = 12'h3C5;   // hoop colour
    localparam logic [11:0] G = 12'h012;   // background colour

    logic        clk = 1'b0;
    logic        reset;
    logic        p_tick;
    logic        video_on;
    logic [9:0]  x, y, upd_x, upd_y;
    logic        upd_req;
    logic [11:0] ball_rgb, hoop_rgb, rgb;
    logic        upd_ack, frame_start, pending;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   fs_count = 0;
    logic fs_last = 1'b0;

    typedef struct packed {
        logic [9:0]  px;
        logic [9:0]  py;
        logic        vo;
        logic [11:0] exp;
    } vec_t;

    vec_t vtab [0:29];

    render_ctrl #(.BG_RGB(G)) dut (
        .clk        (clk),
        .reset      (reset),
        .p_tick     (p_tick),
        .video_on   (video_on),
        .x          (x),
        .y          (y),
        .upd_req    (upd_req),
        .upd_x      (upd_x),
        .upd_y      (upd_y),
        .ball_rgb   (ball_rgb),
        .hoop_rgb   (hoop_rgb),
        .upd_ack    (upd_ack),
        .frame_start(frame_start),
        .pending    (pending),
        .rgb        (rgb)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int px, input int py, input logic vo, input logic [11:0] e);
        vec_t v;
        v.px  = 10'(px);
        v.py  = 10'(py);
        v.vo  = vo;
        v.exp = e;
        return v;
    endfunction

    task automatic chk_v(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_b(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One pixel tick; frame_start is sampled mid-cycle while p_tick is high.
    task automatic tick(input logic [9:0] tx, input logic [9:0] ty, input logic vo);
        x = tx; y = ty; video_on = vo; p_tick = 1'b1;
        #1;
        fs_last = frame_start;
        if (frame_start) fs_count++;
        step();
        p_tick = 1'b0;
    endtask

    task automatic wait_ack(input int max, output int n);
        n = 0;
        while (n < max && !upd_ack) begin
            step();
            n++;
        end
    endtask

    task automatic run_tab(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            tick(vtab[i].px, vtab[i].py, vtab[i].vo);
            chk_v($sformatf("rgb[%0d](%0d,%0d)", i, vtab[i].px, vtab[i].py), rgb, vtab[i].exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   n;
        logic any_ack;

        // Ball at reset position (0,0)
        vtab[0]  = mk(1, 1, 1'b1, B);
        vtab[1]  = mk(15, 15, 1'b1, B);
        vtab[2]  = mk(16, 15, 1'b1, G);
        vtab[3]  = mk(15, 16, 1'b1, G);
        vtab[4]  = mk(560, 200, 1'b1, H);
        vtab[5]  = mk(600, 208, 1'b1, H);
        vtab[6]  = mk(601, 208, 1'b1, G);
        vtab[7]  = mk(580, 199, 1'b1, G);
        vtab[8]  = mk(580, 209, 1'b1, G);
        vtab[9]  = mk(580, 204, 1'b0, 12'h000);
        vtab[10] = mk(700, 500, 1'b0, 12'h000);
        // Ball at (100,50)
        vtab[11] = mk(100, 50, 1'b1, B);
        vtab[12] = mk(115, 65, 1'b1, B);
        vtab[13] = mk(116, 65, 1'b1, G);
        vtab[14] = mk(115, 66, 1'b1, G);
        vtab[15] = mk(99, 50, 1'b1, G);
        vtab[16] = mk(100, 49, 1'b1, G);
        vtab[17] = mk(5, 5, 1'b1, G);
        // Ball clamped to (624,464)
        vtab[18] = mk(624, 464, 1'b1, B);
        vtab[19] = mk(639, 479, 1'b1, B);
        vtab[20] = mk(623, 470, 1'b1, G);
        vtab[21] = mk(639, 463, 1'b1, G);
        vtab[22] = mk(0, 470, 1'b1, G);
        vtab[23] = mk(3, 470, 1'b1, G);
        // Ball at (560,200) overlapping the hoop
        vtab[24] = mk(560, 200, 1'b1, B);
        vtab[25] = mk(575, 208, 1'b1, B);
        vtab[26] = mk(576, 200, 1'b1, H);
        vtab[27] = mk(600, 208, 1'b1, H);
        vtab[28] = mk(575, 209, 1'b1, B);
        vtab[29] = mk(590, 204, 1'b1, H);

        reset = 1'b1; p_tick = 1'b0; video_on = 1'b0; x = '0; y = '0;
        upd_req = 1'b0; upd_x = '0; upd_y = '0;
        ball_rgb = B; hoop_rgb = H;

        repeat (3) @(posedge clk);
        #1;
        chk_v("reset_rgb", rgb, 12'h000);
        chk_b("reset_pending", pending, 1'b0);
        chk_b("reset_ack", upd_ack, 1'b0);
        reset = 1'b0;
        step();
        chk_v("post_reset_rgb", rgb, 12'h000);
        chk_b("post_reset_fs", frame_start, 1'b0);

        // Frame with no updates
        tick(0, 0, 1'b1);
        chk_b("fs_frame1", fs_last, 1'b1);
        run_tab(0, 10);
        chk_b("fs_idle", fs_last, 1'b0);
        tick(580, 204, 1'b1);
        x = 1; y = 1; video_on = 1'b1;
        step();
        chk_v("rgb_hold", rgb, H);

        // Request during active line 200; commit waits for blanking
        tick(50, 200, 1'b1);
        upd_req = 1'b1; upd_x = 100; upd_y = 50;
        step();
        chk_b("pend_active", pending, 1'b1);
        any_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            any_ack |= upd_ack;
        end
        chk_b("no_ack_active", any_ack, 1'b0);
        tick(5, 5, 1'b1);
        chk_v("old_ball_live", rgb, B);
        tick(0, 480, 1'b0);
        wait_ack(6, n);
        chk_i("ack_latency_1", n, 2);
        chk_b("ack_1", upd_ack, 1'b1);
        chk_b("pend_clr_1", pending, 1'b0);
        upd_req = 1'b0;
        step();
        chk_b("ack_pulse", upd_ack, 1'b0);
        tick(0, 0, 1'b1);
        chk_b("fs_frame2", fs_last, 1'b1);
        run_tab(11, 17);

        // Clamped request
        upd_req = 1'b1; upd_x = 700; upd_y = 470;
        step();
        tick(0, 480, 1'b0);
        wait_ack(6, n);
        chk_i("ack_latency_2", n, 2);
        upd_req = 1'b0;
        step();
        tick(0, 0, 1'b1);
        run_tab(18, 23);

        // Ball overlapping hoop
        upd_req = 1'b1; upd_x = 560; upd_y = 200;
        step();
        tick(0, 480, 1'b0);
        wait_ack(6, n);
        upd_req = 1'b0;
        step();
        tick(0, 0, 1'b1);
        run_tab(24, 29);

        // Request held through ack becomes a second request
        upd_req = 1'b1; upd_x = 200; upd_y = 100;
        step();
        chk_b("pend_held", pending, 1'b1);
        tick(0, 480, 1'b0);
        wait_ack(6, n);
        chk_b("ack_held_1", upd_ack, 1'b1);
        upd_x = 300; upd_y = 300;
        step();
        chk_b("no_recapture_ack", pending, 1'b0);
        step();
        chk_b("second_capture", pending, 1'b1);
        chk_b("no_ack_yet", upd_ack, 1'b0);
        wait_ack(6, n);
        chk_i("ack_latency_second", n, 2);
        upd_req = 1'b0;
        step();
        tick(0, 0, 1'b1);
        tick(300, 300, 1'b1);
        chk_v("second_pos", rgb, B);
        tick(200, 100, 1'b1);
        chk_v("first_pos_gone", rgb, G);

        // Origin tick during the COMMIT cycle
        tick(0, 480, 1'b0);
        upd_req = 1'b1; upd_x = 50; upd_y = 60;
        step();
        step();
        tick(0, 0, 1'b1);
        chk_b("fs_in_commit", fs_last, 1'b1);
        chk_b("ack_in_commit", upd_ack, 1'b1);
        upd_req = 1'b0;
        step();
        tick(0, 0, 1'b1);
        tick(50, 60, 1'b1);
        chk_v("commit_origin_pos", rgb, B);

        // Reset during COMMIT discards the update
        tick(0, 480, 1'b0);
        tick(0, 481, 1'b1);
        chk_v("bg_in_blank", rgb, G);
        upd_req = 1'b1; upd_x = 10; upd_y = 10;
        step();
        chk_b("pend_pre_reset", pending, 1'b1);
        step();
        #2;
        reset = 1'b1;
        #1;
        chk_b("async_ack", upd_ack, 1'b0);
        chk_b("async_pending", pending, 1'b0);
        chk_v("async_rgb", rgb, 12'h000);
        chk_b("async_fs", frame_start, 1'b0);
        upd_req = 1'b0;
        step();
        step();
        reset = 1'b0;
        any_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            any_ack |= upd_ack;
        end
        chk_b("no_ack_after_reset", any_ack, 1'b0);
        tick(0, 0, 1'b1);
        tick(5, 5, 1'b1);
        chk_v("live_reset_pos", rgb, B);
        tick(20, 20, 1'b1);
        chk_v("discarded_pos", rgb, G);

        chk_i("frame_start_count", fs_count, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
